timer_controller: RTL
=====================

TIMER_CONTROLLER -- requirements
Module: timer_controller

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, giving the number of timer channels (1..4).
REQ-002 The block SHALL have parameter BASE_ADDR, default 8'h40, giving the Picoblaze port base address.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-004 The block SHALL have port reset_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-005 The block SHALL have port port_id, input, 8 bits: the Picoblaze port address.
REQ-006 The block SHALL have port write_strobe, input, 1 bit: write qualifier; out_port is captured on this cycle.
REQ-007 The block SHALL have port out_port, input, 8 bits: write data.
REQ-008 The block SHALL have port in_port, output, 8 bits: registered read data.
REQ-009 The block SHALL have port interrupt, output, 1 bit: the interrupt request to Picoblaze.
REQ-010 The block SHALL have port interrupt_ack, input, 1 bit: the one-cycle acknowledge from Picoblaze.

Function
REQ-011 Register map, relative to BASE_ADDR + ch*8:
- +0..+2: compare bytes 0..2, written to a shadow register.
- +3: compare byte 3; a write SHALL commit all 32 bits {b3, shadow} atomically.
- +4: control (bit0 enable, bit1 one_shot).
- +5: status (bit0 pending; writing 1 clears it).
REQ-012 Global registers: BASE+0x20 vector (read-only: bit7 valid, bits1:0 serviced channel); BASE+0x21 mask (bit n = channel n interrupt enable).
REQ-013 in_port SHALL be registered: value for the current port_id appears 1 cycle later. Unmapped addresses SHALL read 8'h00.
REQ-014 Counting: while enable=1, the channel's 32-bit count SHALL increment by 1 each cycle. While enable=0, count SHALL be held at 0.
REQ-015 Expiry: when enable=1 and count >= compare, count SHALL load 0 and pending SHALL be set on the next edge. The period is therefore compare+1 cycles; compare=0 expires every cycle.
REQ-016 One-shot: on expiry with one_shot=1, enable SHALL be cleared in the same edge.
REQ-017 A compare commit while enabled SHALL take effect immediately. If count already exceeds the new compare, expiry occurs on the next cycle.
REQ-018 If a pending set and a software clear occur in the same cycle, the set SHALL win.
REQ-019 A control write with enable=0 SHALL NOT clear pending.
REQ-020 Interrupt FSM states:
- IDLE: go to ASSERT when any (pending & mask) != 0.
- ASSERT: interrupt=1; on interrupt_ack, latch vector = lowest-index pending&mask channel, set valid, go to SERVICE.
- SERVICE: interrupt=0; when the latched channel's pending clears, clear valid and go to IDLE.
REQ-021 If mask removes all pending channels while in ASSERT, the FSM SHALL return to IDLE and deassert interrupt.
REQ-022 interrupt SHALL be a registered output, asserted 1 cycle after entering ASSERT conditions and never during SERVICE.
REQ-023 interrupt_ack received outside ASSERT SHALL be ignored.

Reset
REQ-024 While reset_n=0, asynchronously:
- all counts, compares, shadows, control, pending and mask SHALL be 0;
- the FSM SHALL be IDLE;
- interrupt SHALL be 0, in_port 8'h00, vector 8'h00.
REQ-025 Reset asserted mid-count or mid-SERVICE SHALL abandon the operation with no interrupt on release.

Structure
REQ-026 Package timer_ctrl_pkg SHALL hold the register offsets, control/status bit positions, and the FSM state enum (IDLE, ASSERT, SERVICE).
REQ-027 Sub-module timer_channel (count, compare, shadow, control, pending) SHALL be instantiated NUM_CH times. Address decode, read mux and FSM SHALL be in the top level.

Verification
REQ-028 Channel 0: compare=9, enable, mask=1 -> pending at cycle 10 after enable; interrupt asserted; repeats every 10 cycles.
REQ-029 one_shot=1, compare=4 -> exactly one expiry; enable reads 0 afterward; count stays 0.
REQ-030 Channels 1 and 2 expire in the same cycle, mask=8'h0F, ack -> vector=8'h81; after clearing ch1 pending, interrupt reasserts and the next ack gives vector=8'h82.
REQ-031 Write compare bytes 0..2 = 8'hFF with byte 3 unwritten -> active compare unchanged; write byte 3 = 8'h00 -> compare=32'h00FFFFFF in one step.
REQ-032 Software writes 1 to status in the same cycle as an expiry -> pending remains 1.
REQ-033 reset_n pulsed low during SERVICE -> interrupt=0, vector=8'h00 and all registers read 0 with no clock edge required.

Source files
------------

// File: rtl/timer_ctrl_pkg.sv
// timer_ctrl_pkg
// Shared definitions for the Picoblaze timer controller: per-channel register
// offsets, global register offsets, control/status bit positions, the
// interrupt FSM state type and a lowest-index priority helper.
package timer_ctrl_pkg;

  // Per-channel register offsets (relative to BASE_ADDR + ch*8)
  localparam logic [2:0] REG_CMP0   = 3'd0;
  localparam logic [2:0] REG_CMP1   = 3'd1;
  localparam logic [2:0] REG_CMP2   = 3'd2;
  localparam logic [2:0] REG_CMP3   = 3'd3;
  localparam logic [2:0] REG_CTRL   = 3'd4;
  localparam logic [2:0] REG_STATUS = 3'd5;

  // Global register offsets (relative to BASE_ADDR)
  localparam logic [7:0] REG_VECTOR = 8'h20;
  localparam logic [7:0] REG_MASK   = 8'h21;

  // Bit positions
  localparam int CTRL_ENABLE_BIT    = 0;
  localparam int CTRL_ONE_SHOT_BIT  = 1;
  localparam int STATUS_PENDING_BIT = 0;
  localparam int VECTOR_VALID_BIT   = 7;

  // Channel slots decoded by the top level (NUM_CH may use fewer)
  localparam int MAX_CH = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

  // Index of the lowest set bit; 0 when nothing is set
  function automatic logic [1:0] lowest_index(input logic [3:0] req);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (req[i]) begin
        idx = 2'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// timer_channel
// One 32-bit timer channel: free-running count, active compare, 24-bit compare
// shadow (bytes 0..2), control (enable, one_shot) and the pending flag.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   wr_en                 write strobe already decoded for this channel
//   wr_reg, wr_data       channel register offset and write data
//   compare               active compare value
//   enable, one_shot      control bits
//   pending               expiry flag (write-1-to-clear)
module timer_channel
  import timer_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_en,
  input  logic [2:0]  wr_reg,
  input  logic [7:0]  wr_data,
  output logic [31:0] compare,
  output logic        enable,
  output logic        one_shot,
  output logic        pending
);

  logic [31:0] count_r;
  logic [31:0] compare_r;
  logic [23:0] shadow_r;
  logic        enable_r;
  logic        one_shot_r;
  logic        pending_r;

  logic        expiry_s;
  logic        ctrl_wr_s;
  logic        status_clr_s;
  logic        enable_nxt_s;
  logic [31:0] count_nxt_s;

  // Expiry detection and next values of enable and count
  always_comb begin
    expiry_s     = enable_r && (count_r >= compare_r);
    ctrl_wr_s    = wr_en && (wr_reg == REG_CTRL);
    status_clr_s = wr_en && (wr_reg == REG_STATUS) && wr_data[STATUS_PENDING_BIT];
    // A software control write overrides the one-shot auto-disable
    if (ctrl_wr_s) begin
      enable_nxt_s = wr_data[CTRL_ENABLE_BIT];
    end else if (expiry_s && one_shot_r) begin
      enable_nxt_s = 1'b0;
    end else begin
      enable_nxt_s = enable_r;
    end
    // Count stays 0 on the enabling edge so the first period is compare+1 cycles
    if (!enable_r || !enable_nxt_s || expiry_s) begin
      count_nxt_s = 32'd0;
    end else begin
      count_nxt_s = count_r + 32'd1;
    end
  end

  // Channel state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_r    <= 32'd0;
      compare_r  <= 32'd0;
      shadow_r   <= 24'd0;
      enable_r   <= 1'b0;
      one_shot_r <= 1'b0;
      pending_r  <= 1'b0;
    end else begin
      count_r  <= count_nxt_s;
      enable_r <= enable_nxt_s;
      if (ctrl_wr_s) begin
        one_shot_r <= wr_data[CTRL_ONE_SHOT_BIT];
      end
      if (wr_en) begin
        case (wr_reg)
          REG_CMP0: shadow_r[7:0]   <= wr_data;
          REG_CMP1: shadow_r[15:8]  <= wr_data;
          REG_CMP2: shadow_r[23:16] <= wr_data;
          REG_CMP3: compare_r       <= {wr_data, shadow_r};
          default:  shadow_r        <= shadow_r;
        endcase
      end
      // Hardware set wins over a simultaneous software clear
      if (expiry_s) begin
        pending_r <= 1'b1;
      end else if (status_clr_s) begin
        pending_r <= 1'b0;
      end
    end
  end

  assign compare  = compare_r;
  assign enable   = enable_r;
  assign one_shot = one_shot_r;
  assign pending  = pending_r;

endmodule

// File: rtl/timer_controller.sv
// timer_controller
// Picoblaze-attached multi-channel timer with a single interrupt line.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   port_id, write_strobe,       Picoblaze I/O address, write qualifier and
//   out_port                     write data
//   in_port                      registered read data (1 cycle after port_id)
//   interrupt, interrupt_ack     registered interrupt request / acknowledge
module timer_controller
  import timer_ctrl_pkg::*;
#(
  parameter int         NUM_CH    = 4,
  parameter logic [7:0] BASE_ADDR = 8'h40
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] port_id,
  input  logic       write_strobe,
  input  logic [7:0] out_port,
  output logic [7:0] in_port,
  output logic       interrupt,
  input  logic       interrupt_ack
);

  logic [7:0]             offset_s;
  logic [1:0]             ch_sel_s;
  logic                   ch_space_s;
  logic [MAX_CH-1:0]      ch_wr_s;
  logic [MAX_CH-1:0]      en_s;
  logic [MAX_CH-1:0]      os_s;
  logic [MAX_CH-1:0]      pend_s;
  logic [MAX_CH-1:0]      pm_s;
  logic [MAX_CH-1:0][31:0] cmp_s;
  logic [7:0]             rd_data_s;

  logic [7:0]             mask_r;
  logic [7:0]             vector_r;
  logic [7:0]             in_port_r;
  logic                   interrupt_r;
  irq_state_e             state_r;

  // Address decode into channel slot / register offset and per-channel write strobes
  always_comb begin
    offset_s   = port_id - BASE_ADDR;
    ch_sel_s   = offset_s[4:3];
    ch_space_s = (offset_s[7:5] == 3'd0) && ({1'b0, ch_sel_s} < 3'(NUM_CH));
    for (int i = 0; i < MAX_CH; i++) begin
      ch_wr_s[i] = write_strobe && ch_space_s && (ch_sel_s == 2'(i));
    end
  end

  for (genvar g = 0; g < MAX_CH; g++) begin : g_ch
    if (g < NUM_CH) begin : g_used
      timer_channel u_channel (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (ch_wr_s[g]),
        .wr_reg   (offset_s[2:0]),
        .wr_data  (out_port),
        .compare  (cmp_s[g]),
        .enable   (en_s[g]),
        .one_shot (os_s[g]),
        .pending  (pend_s[g])
      );
    end else begin : g_unused
      assign cmp_s[g]  = 32'd0;
      assign en_s[g]   = 1'b0;
      assign os_s[g]   = 1'b0;
      assign pend_s[g] = 1'b0;
    end
  end

  assign pm_s = pend_s & mask_r[MAX_CH-1:0];

  // Read mux; unmapped addresses return 0
  always_comb begin
    rd_data_s = 8'h00;
    if (ch_space_s) begin
      case (offset_s[2:0])
        REG_CMP0:   rd_data_s = cmp_s[ch_sel_s][7:0];
        REG_CMP1:   rd_data_s = cmp_s[ch_sel_s][15:8];
        REG_CMP2:   rd_data_s = cmp_s[ch_sel_s][23:16];
        REG_CMP3:   rd_data_s = cmp_s[ch_sel_s][31:24];
        REG_CTRL:   rd_data_s = {6'd0, os_s[ch_sel_s], en_s[ch_sel_s]};
        REG_STATUS: rd_data_s = {7'd0, pend_s[ch_sel_s]};
        default:    rd_data_s = 8'h00;
      endcase
    end else if (offset_s == REG_VECTOR) begin
      rd_data_s = vector_r;
    end else if (offset_s == REG_MASK) begin
      rd_data_s = mask_r;
    end else begin
      rd_data_s = 8'h00;
    end
  end

  // Interrupt mask register and registered read data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_r    <= 8'h00;
      in_port_r <= 8'h00;
    end else begin
      in_port_r <= rd_data_s;
      if (write_strobe && (offset_s == REG_MASK)) begin
        mask_r <= out_port;
      end
    end
  end

  // Interrupt FSM with registered interrupt and vector
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      interrupt_r <= 1'b0;
      vector_r    <= 8'h00;
    end else begin
      case (state_r)
        IDLE: begin
          if (|pm_s) begin
            state_r     <= ASSERT;
            interrupt_r <= 1'b1;
          end else begin
            interrupt_r <= 1'b0;
          end
        end
        ASSERT: begin
          // Masking away every request withdraws the interrupt before an ack
          if (!(|pm_s)) begin
            state_r     <= IDLE;
            interrupt_r <= 1'b0;
          end else if (interrupt_ack) begin
            state_r     <= SERVICE;
            interrupt_r <= 1'b0;
            vector_r    <= {1'b1, 5'd0, lowest_index(pm_s)};
          end else begin
            interrupt_r <= 1'b1;
          end
        end
        SERVICE: begin
          interrupt_r <= 1'b0;
          if (!pend_s[vector_r[1:0]]) begin
            vector_r[VECTOR_VALID_BIT] <= 1'b0;
            state_r                    <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          interrupt_r <= 1'b0;
          vector_r    <= 8'h00;
        end
      endcase
    end
  end

  assign in_port   = in_port_r;
  assign interrupt = interrupt_r;

endmodule
